// File: rtl/namuru_corr_pkg.sv
// Shared correlator types and arithmetic helpers: sign/mag sample decode and
// symmetric saturating accumulation.
package namuru_corr_pkg;

  localparam int unsigned ACC_W_DEF = 16;
  localparam int unsigned MIX_W     = 4;
  localparam int unsigned SAT_W     = 34;

  typedef struct packed {
    logic sign;
    logic mag;
  } sm2_t;

  // Raw IF sample: +-1 / +-3
  function automatic logic signed [2:0] decode_if(input sm2_t s);
    logic signed [2:0] v;
    v = s.mag ? 3'sd3 : 3'sd1;
    return s.sign ? v : -v;
  endfunction

  // NCO carrier: +-1 / +-2
  function automatic logic signed [2:0] decode_carr(input sm2_t s);
    logic signed [2:0] v;
    v = s.mag ? 3'sd2 : 3'sd1;
    return s.sign ? v : -v;
  endfunction

  // Add a product and clamp to +-(2^(w-1)-1); the wide sum cannot overflow
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [MIX_W-1:0] b,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] lim;
    logic signed [SAT_W-1:0] s;
    lim = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    s   = a + SAT_W'(b);
    if (s > lim) begin
      s = lim;
    end else if (s < -lim) begin
      s = -lim;
    end
    return s;
  endfunction

endpackage

// File: rtl/carrier_mixer.sv
// One correlator arm's product: IF sample x carrier x code chip, range +-6.
module carrier_mixer
  import namuru_corr_pkg::*;
(
  input  sm2_t                    if_s,
  input  sm2_t                    carr,
  input  logic                    code_bit,
  output logic signed [MIX_W-1:0] mix_c
);

  logic signed [MIX_W-1:0] prod;

  always_comb begin
    prod  = MIX_W'(decode_if(if_s)) * MIX_W'(decode_carr(carr));
    mix_c = code_bit ? prod : -prod;
  end

endmodule

// File: rtl/carrier_mixer_accum.sv
// Correlator arm: carrier wipe-off and code mix, saturating I/Q integration,
// dump latch with valid/ack handshake and sticky overrun.
module carrier_mixer_accum
  import namuru_corr_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic                    if_sign,
  input  logic                    if_mag,
  input  logic                    i_sign,
  input  logic                    i_mag,
  input  logic                    q_sign,
  input  logic                    q_mag,
  input  logic                    code_bit,
  input  logic                    dump,
  input  logic                    dump_ack,
  output logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] acc_q,
  output logic                    dump_valid,
  output logic                    overrun
);

  sm2_t                    if_smp;
  sm2_t                    carr_i;
  sm2_t                    carr_q;
  logic signed [MIX_W-1:0] mix_i_c;
  logic signed [MIX_W-1:0] mix_q_c;

  logic signed [MIX_W-1:0] mix_i_s1;
  logic signed [MIX_W-1:0] mix_q_s1;
  logic                    en_s1;
  logic                    dump_s1;

  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;
  logic signed [ACC_W-1:0] sum_i_nxt;
  logic signed [ACC_W-1:0] sum_q_nxt;

  assign if_smp = {if_sign, if_mag};
  assign carr_i = {i_sign, i_mag};
  assign carr_q = {q_sign, q_mag};

  carrier_mixer u_mix_i (
    .if_s     (if_smp),
    .carr     (carr_i),
    .code_bit (code_bit),
    .mix_c    (mix_i_c)
  );

  carrier_mixer u_mix_q (
    .if_s     (if_smp),
    .carr     (carr_q),
    .code_bit (code_bit),
    .mix_c    (mix_q_c)
  );

  // Stage 1: register products and qualifiers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_i_s1 <= '0;
      mix_q_s1 <= '0;
      en_s1    <= 1'b0;
      dump_s1  <= 1'b0;
    end else begin
      mix_i_s1 <= mix_i_c;
      mix_q_s1 <= mix_q_c;
      en_s1    <= sample_en;
      dump_s1  <= dump;
    end
  end

  // The dump-cycle sample opens the new interval rather than closing the old one
  always_comb begin
    sum_i_nxt = sum_i;
    sum_q_nxt = sum_q;
    if (dump_s1) begin
      sum_i_nxt = en_s1 ? ACC_W'(mix_i_s1) : '0;
      sum_q_nxt = en_s1 ? ACC_W'(mix_q_s1) : '0;
    end else if (en_s1) begin
      sum_i_nxt = ACC_W'(sat_add(SAT_W'(sum_i), mix_i_s1, ACC_W));
      sum_q_nxt = ACC_W'(sat_add(SAT_W'(sum_q), mix_q_s1, ACC_W));
    end
  end

  // Stage 2: accumulate, latch on dump, run the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_i      <= '0;
      sum_q      <= '0;
      acc_i      <= '0;
      acc_q      <= '0;
      dump_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sum_i <= sum_i_nxt;
      sum_q <= sum_q_nxt;
      if (dump_s1) begin
        acc_i      <= sum_i;
        acc_q      <= sum_q;
        dump_valid <= 1'b1;
        if (dump_valid && !dump_ack) begin
          overrun <= 1'b1;
        end
      end else if (dump_ack && dump_valid) begin
        dump_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_carrier_mixer_accum.sv
// Self-checking bench: 16-bit and 8-bit arms driven in parallel against an
// interval-level integer model, directed scenarios followed by random traffic.
module tb_carrier_mixer_accum;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample_en = 1'b0;
  logic if_sign = 1'b0, if_mag = 1'b0;
  logic i_sign = 1'b0, i_mag = 1'b0, q_sign = 1'b0, q_mag = 1'b0;
  logic code_bit = 1'b0, dump = 1'b0, dump_ack = 1'b0;

  logic signed [15:0] acc16_i, acc16_q;
  logic signed [7:0]  acc8_i, acc8_q;
  logic dv16, ov16, dv8, ov8;

  int tests = 0;
  int fails = 0;

  // Model state: index 0 is the 16-bit arm, index 1 the 8-bit arm
  int wid[2] = '{16, 8};
  int m_sum_i[2], m_sum_q[2], m_cap_i[2], m_cap_q[2], m_out_i[2], m_out_q[2];
  bit m_pend, m_valid, m_ovr;

  int ifvals[4] = '{-3, -1, 1, 3};
  int cvals[4]  = '{-2, -1, 1, 2};

  always #5 clk = ~clk;

  carrier_mixer_accum #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .sample_en(sample_en), .if_sign(if_sign), .if_mag(if_mag),
    .i_sign(i_sign), .i_mag(i_mag), .q_sign(q_sign), .q_mag(q_mag), .code_bit(code_bit),
    .dump(dump), .dump_ack(dump_ack), .acc_i(acc16_i), .acc_q(acc16_q),
    .dump_valid(dv16), .overrun(ov16)
  );

  carrier_mixer_accum #(.ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .sample_en(sample_en), .if_sign(if_sign), .if_mag(if_mag),
    .i_sign(i_sign), .i_mag(i_mag), .q_sign(q_sign), .q_mag(q_mag), .code_bit(code_bit),
    .dump(dump), .dump_ack(dump_ack), .acc_i(acc8_i), .acc_q(acc8_q),
    .dump_valid(dv8), .overrun(ov8)
  );

  function automatic int clamp(input int v, input int w);
    int lim;
    lim = (1 << (w - 1)) - 1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("acc16_i", acc16_i, m_out_i[0]);
    chk("acc16_q", acc16_q, m_out_q[0]);
    chk("acc8_i", acc8_i, m_out_i[1]);
    chk("acc8_q", acc8_q, m_out_q[1]);
    chk("valid16", dv16, m_valid);
    chk("overrun16", ov16, m_ovr);
    chk("valid8", dv8, m_valid);
    chk("overrun8", ov8, m_ovr);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_sum_i[k] = 0; m_sum_q[k] = 0; m_cap_i[k] = 0; m_cap_q[k] = 0;
      m_out_i[k] = 0; m_out_q[k] = 0;
    end
    m_pend = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  // One clock: present inputs, advance the model, check every output
  task automatic drive(input bit en, input int ifv, input int ci, input int cq,
                       input int code, input bit dmp, input bit ack);
    int p_i, p_q;
    sample_en = en;
    if_sign = (ifv > 0);  if_mag = (ifv == 3 || ifv == -3);
    i_sign  = (ci > 0);   i_mag  = (ci == 2 || ci == -2);
    q_sign  = (cq > 0);   q_mag  = (cq == 2 || cq == -2);
    code_bit = (code > 0);
    dump = dmp;
    dump_ack = ack;
    @(posedge clk);
    #1;
    // A dump presented last cycle lands on this edge, together with this cycle's ack
    if (m_pend) begin
      for (int k = 0; k < 2; k++) begin
        m_out_i[k] = m_cap_i[k];
        m_out_q[k] = m_cap_q[k];
      end
      if (m_valid && !ack) m_ovr = 1'b1;
      m_valid = 1'b1;
    end else if (ack && m_valid) begin
      m_valid = 1'b0;
      m_ovr = 1'b0;
    end
    p_i = en ? ifv * ci * code : 0;
    p_q = en ? ifv * cq * code : 0;
    for (int k = 0; k < 2; k++) begin
      if (dmp) begin
        m_cap_i[k] = m_sum_i[k]; m_cap_q[k] = m_sum_q[k];
        m_sum_i[k] = p_i;        m_sum_q[k] = p_q;
      end else begin
        m_sum_i[k] = clamp(m_sum_i[k] + p_i, wid[k]);
        m_sum_q[k] = clamp(m_sum_q[k] + p_q, wid[k]);
      end
    end
    m_pend = dmp;
    chk_all();
  endtask

  task automatic samp(input int n, input bit en, input int ifv, input int ci,
                      input int cq, input int code);
    for (int j = 0; j < n; j++) drive(en, ifv, ci, cq, code, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit dmp, input bit ack);
    drive(1'b0, 1, 1, 1, 1, dmp, ack);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_clear();
    chk_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all();
    rst = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    // Gain and sign: +3 x +2 / -1, code +1
    samp(10, 1'b1, 3, 2, -1, 1);
    idle(1'b1, 1'b0);
    chk("gain_valid_early", dv16, 0);
    idle(1'b0, 1'b0);
    chk("gain_i", acc16_i, 60);
    chk("gain_q", acc16_q, -30);
    chk("gain_valid", dv16, 1);
    idle(1'b0, 1'b1);

    // Code flip
    samp(10, 1'b1, 3, 2, -1, -1);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    chk("flip_i", acc16_i, -60);
    chk("flip_q", acc16_q, 30);
    idle(1'b0, 1'b1);

    // Saturation, recovery by one step, then negative clamp
    samp(30, 1'b1, 3, 2, 2, 1);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);
    chk("sat_pos8", acc8_i, 127);
    chk("sat_pos16", acc16_i, 180);
    idle(1'b0, 1'b1);
    samp(30, 1'b1, 3, 2, 2, 1);
    samp(1, 1'b1, -1, 1, 1, 1);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);
    chk("sat_back8", acc8_i, 126);
    idle(1'b0, 1'b1);
    samp(30, 1'b1, 3, 2, 2, -1);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);
    chk("sat_neg8", acc8_i, -127);
    chk("sat_neg16", acc16_i, -180);
    idle(1'b0, 1'b1);

    // Two dumps without ack: overrun, second data visible
    samp(3, 1'b1, 3, 2, 2, 1);
    idle(1'b1, 1'b0);
    samp(2, 1'b1, 3, 1, 1, 1);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    chk("ovr_flag", ov16, 1);
    chk("ovr_data", acc16_i, 6);
    idle(1'b0, 1'b1);
    chk("ack_valid", dv16, 0);
    chk("ack_ovr", ov16, 0);
    // Dump with ack in the latch cycle: no overrun
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    samp(1, 1'b1, 1, 1, 1, 1);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);
    chk("same_ack_ovr", ov16, 0);
    chk("same_ack_valid", dv16, 1);
    idle(1'b0, 1'b1);
    chk("ack_alone", {ov16, dv16}, 0);

    // Interval boundary with gapped samples
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 3, 2, 1, 1, 1'b0, 1'b0);
      drive(1'b0, 3, 2, 1, 1, 1'b0, 1'b0);
    end
    drive(1'b1, 3, 2, 1, 1, 1'b1, 1'b0);
    drive(1'b0, 3, 2, 1, 1, 1'b0, 1'b0);
    chk("gap_first", acc16_i, 24);
    drive(1'b1, 3, 2, 1, 1, 1'b0, 1'b1);
    drive(1'b0, 3, 2, 1, 1, 1'b0, 1'b0);
    drive(1'b1, 3, 2, 1, 1, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    chk("gap_second", acc16_i, 18);
    idle(1'b0, 1'b1);

    // Back-to-back dumps: second interval holds one sample
    drive(1'b1, 3, 2, 2, 1, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    chk("b2b_second", acc16_i, 6);
    idle(1'b0, 1'b1);

    // Reset mid-interval
    samp(5, 1'b1, 3, 2, 2, 1);
    do_reset();
    samp(4, 1'b1, 3, 2, 2, 1);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    chk("post_rst_i", acc16_i, 24);
    chk("post_rst_ovr", ov16, 0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(3, 0) != 0,
            ifvals[$urandom_range(3, 0)], cvals[$urandom_range(3, 0)],
            cvals[$urandom_range(3, 0)], ($urandom_range(1, 0) != 0) ? 1 : -1,
            $urandom_range(11, 0) == 0, $urandom_range(3, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/carrier_mixer_accum.md
# carrier_mixer_accum

Single correlator arm of the tracking channel, directly downstream of `carrier_nco`. Each enabled clock it wipes the carrier off a 2-bit raw IF sample using the NCO's 2-bit I/Q carrier, multiplies by the local code chip, and integrates into I/Q accumulators. A dump pulse latches the integration into output registers, held under a valid/ack handshake toward the channel's register interface.

## Interface
- `ACC_W`, 16: accumulator and output width (signed, two's complement), legal 8..32.
- `clk`  in  1  sample clock (16.368 MHz), same clock as `carrier_nco`.
- `rst`  in  1  asynchronous, active-high reset.
- `sample_en`  in  1  current IF sample and carrier/code inputs are valid.
- `if_sign`, `if_mag`  in  1 each  raw IF sample: sign 1 means positive; mag 0 means 1, mag 1 means 3.
- `i_sign`, `i_mag`, `q_sign`, `q_mag`  in  1 each  NCO carrier: sign 1 means positive; mag 0 means 1, mag 1 means 2.
- `code_bit`  in  1  local code chip: 1 means +1, 0 means −1.
- `dump`  in  1  one-cycle pulse; closes the current integration interval.
- `dump_ack`  in  1  consumer has read the outputs.
- `acc_i`, `acc_q`  out  ACC_W  latched integration results.
- `dump_valid`  out  1  latched results are unread.
- `overrun`  out  1  sticky: a latch overwrote unread results.

## Operation
- Mix: `mix_i = if_val * carr_i * code`, `mix_q = if_val * carr_q * code`. Range ±6; 4-bit signed is sufficient.
- Stage 1 registers `mix_i`, `mix_q`, `sample_en` and `dump`.
- Stage 2 accumulates, using the stage-1 values.
  - Delayed dump = 1: `acc_i/acc_q` ← accumulators; accumulators ← current product if the delayed `sample_en` = 1, else 0.
  - Otherwise, if the delayed `sample_en` = 1: accumulators += product.
- Interval convention: the sample presented in the `dump` cycle is the first sample of the new interval, not the last of the old one.
- Saturation: accumulators clamp symmetrically to ±(2^(ACC_W−1)−1) and never wrap.
  - A clamped value stays clamped until the product drives it back inside the range.
- Handshake, evaluated at the stage-2 edge:
  - Latch with `dump_valid` = 0, or with `dump_ack` = 1 in the same cycle: `dump_valid` ← 1, `overrun` unchanged.
  - Latch with `dump_valid` = 1 and `dump_ack` = 0: data overwritten, `dump_valid` stays 1, `overrun` ← 1.
  - `dump_ack` with no latch: `dump_valid` ← 0, `overrun` ← 0.
  - `dump_ack` while `dump_valid` = 0: ignored.
- Two `dump` pulses in consecutive cycles are legal. Each latches; the second captures at most one sample.

## Timing
- Reset values: all outputs, accumulators and pipeline registers are 0.
- Reset asserted mid-interval discards the partial sum and any pending pipeline dump.
- The first interval after reset starts with the first enabled sample.
- Latency: inputs sampled at edge n (stage 1). A `dump` at edge n produces new `acc_i/acc_q` and `dump_valid` = 1 after edge n+1.
- `dump_ack` acts at the next edge; `dump_valid` falls one cycle after the ack is sampled.
- Throughput: one sample per clock, with no stalls.

## Structure
- Shared package `namuru_corr_pkg` holds:
  - default `ACC_W`;
  - typedef for the 2-bit sign/mag sample;
  - functions `decode_if` (±1/±3), `decode_carr` (±1/±2) and `sat_add`.
- Sub-module `carrier_mixer`: combinational if×carrier×code product for one arm, instantiated twice (I and Q).
- The top holds the pipeline, accumulators, latch and handshake.

## Test plan
- Gain and sign:
  - stimulus: `if` = +3, carrier I = +2, carrier Q = −1, `code_bit` = 1, 10 enabled samples, then `dump`;
  - response: `acc_i` = 60, `acc_q` = −30, `dump_valid` = 1 two cycles after `dump`.
- Code flip:
  - stimulus: same as gain and sign with `code_bit` = 0;
  - response: `acc_i` = −60, `acc_q` = +30.
- Saturation:
  - stimulus: `ACC_W` = 8, 30 samples of +6, then `dump`;
  - response: `acc_i` = 127.
  - stimulus: then 30 samples of −6;
  - response: −127, never −128.
- Handshake:
  - stimulus: dump twice without ack;
  - response: `overrun` = 1, second data visible.
  - stimulus: dump with `dump_ack` in the same stage-2 cycle;
  - response: `overrun` stays 0, `dump_valid` stays 1.
  - stimulus: ack alone;
  - response: both flags clear.
- Interval boundary and gaps:
  - stimulus: `sample_en` toggling 1010…, `dump` on an enabled sample;
  - response: that sample is counted in the next interval only; disabled cycles contribute 0.
- Reset mid-interval:
  - stimulus: assert `rst` after 5 samples, release, 4 samples, then `dump`;
  - response: outputs 0 during reset, `acc_i` reflects only the 4 post-reset samples.
